ctrl_unit: RTL and testbench
============================

CTRL_UNIT -- requirements
Module: ctrl_unit

Interface
REQ-001 SHALL have ports: clk in 1 system clock; rst in 1 synchronous active-high reset; one clock, reset sampled only on rising clk.
REQ-002 SHALL have inputs: OPCODE in 6 IR[31:26]; FUNCT in 6 IR[5:0]; ULA_OVERFLOW, ULA_ZERO, ULA_EQ in 1 each, combinational ALU flags.
REQ-003 SHALL have 1-bit outputs: PC_w, crtl_memwrite, crtl_irwrite, crtl_regwrite, crtl_ulasrca, crtl_memDataRegWrite, crtl_rega, crtl_regb, crtl_regaluout, crtl_regepc, all datapath write/select strobes.
REQ-004 SHALL have multi-bit outputs: crtl_error 2, crtl_iord 2, crtl_regdst 3, crtl_memtoreg 4, crtl_ulasrcb 2, crtl_pcsource 3, crtl_ls 2, crtl_ss 2, crtl_muxshf 2, ULA_CRTL_out 3.

Function
REQ-005 SHALL be a registered Moore FSM; every output a function of current state, OPCODE and FUNCT only, except branch PC_w (REQ-014).
REQ-006 SHALL use encodings: iord 0=PC,1=error vector,2=ALUOut; error 0=addr 253,1=addr 254; regdst 0=rt,1=rd,2=$31; memtoreg 1=ALUOut,8=PC,9=load_size; ulasrca 0=PC,1=A; ulasrcb 0=B,1=const 4,2=signext,3=signext<<2; pcsource 0=ALU result,2=ALUOut,3=A,4=jump target,5=load_size; ULA_CRTL_out 001 add,010 sub,011 and; ls/ss 0=word,2=byte.
REQ-007 SHALL drive every output 0 in any state not asserting it.
REQ-008 FETCH0-FETCH1: iord=0, ulasrca=0, ulasrcb=1, ULA add (memory wait states); FETCH2: crtl_irwrite=1, PC_w=1, pcsource=0 (PC<=PC+4).
REQ-009 DECODE: crtl_rega=crtl_regb=1; ulasrca=0, ulasrcb=3, add, crtl_regaluout=1 (branch target); next state by OPCODE.
REQ-010 Supported: R-type (OPCODE 0) FUNCT 0x20 add, 0x22 sub, 0x24 and, 0x08 jr; I-type 0x08 addi, 0x23 lw, 0x2B sw, 0x04 beq, 0x05 bne; J-type 0x02 j, 0x03 jal; any other OPCODE or R FUNCT -> EXC_OPC.
REQ-011 R_EXEC: ulasrca=1, ulasrcb=0, ALU op per FUNCT, regaluout=1; add/sub with ULA_OVERFLOW=1 -> EXC_OVF, else R_WB (regdst=1, memtoreg=1, regwrite=1) -> FETCH0; jr -> JR (pcsource=3, PC_w=1) -> FETCH0.
REQ-012 ADDI_EXEC: ulasrca=1, ulasrcb=2, add, regaluout=1; overflow -> EXC_OVF, else ADDI_WB (regdst=0, memtoreg=1, regwrite=1).
REQ-013 MEM_ADDR (lw/sw): A+signext into ALUOut; sw -> SW (iord=2, memwrite=1, ss=0) -> FETCH0; lw -> LW0, LW1 (iord=2, wait), LW2 (memDataRegWrite=1), LW_WB (regdst=0, memtoreg=9, ls=0, regwrite=1).
REQ-014 BRANCH: ulasrca=1, ulasrcb=0, sub, pcsource=2; PC_w=ULA_EQ for beq, ~ULA_EQ for bne; one cycle -> FETCH0.
REQ-015 J: pcsource=4, PC_w=1. JAL: regdst=2, memtoreg=8, regwrite=1, pcsource=4, PC_w=1, single cycle (PC+4 written before PC update).
REQ-016 EXC_OPC/EXC_OVF: EXC0 ulasrca=0, ulasrcb=1, sub, crtl_regepc=1 (EPC<=PC-4); EXC1-EXC2 iord=1, error per cause (wait); EXC3 memDataRegWrite=1; EXC4 ls=2, pcsource=5, PC_w=1 -> FETCH0.
REQ-017 Overflow detection SHALL suppress regwrite for that instruction; no state SHALL assert both memwrite and regwrite.
REQ-018 Instruction latency SHALL be: R/addi 6, lw 9, sw 6, branch/jr/j/jal 5 cycles, exception 10 cycles after DECODE entry plus fetch.

Reset
REQ-019 rst=1 SHALL force state RESET and all outputs 0 on the next edge, including mid-instruction and mid-exception.
REQ-020 RESET SHALL last one cycle with no strobes, then FETCH0.

Structure
REQ-021 State encodings, opcode/funct constants, mux select and ALU op constants SHALL live in shared package cpu_ctrl_pkg used by datapath muxes.
REQ-022 Single module, no sub-modules; next-state and output decode in separate combinational blocks.

Verification
REQ-023 rst pulse mid-LW1 -> next cycle state RESET, all outputs 0; following cycle FETCH0 with iord=0.
REQ-024 OPCODE 0,FUNCT 0x20, OVERFLOW=0 -> R_WB cycle regwrite=1, regdst=1, memtoreg=1; FETCH0 6 cycles after FETCH0.
REQ-025 addi with ULA_OVERFLOW=1 in ADDI_EXEC -> regwrite never asserted, regepc=1 in EXC0, iord=1 error=1, then PC_w with pcsource=5.
REQ-026 beq with ULA_EQ=1 -> PC_w=1, pcsource=2; bne with ULA_EQ=1 -> PC_w=0; both return to FETCH0.
REQ-027 OPCODE 0x3F -> DECODE -> EXC0 with error=0 in EXC1-EXC2; lw 0x23 -> memDataRegWrite in LW2, regwrite with memtoreg=9 in LW_WB.

Source files
------------

// File: rtl/cpu_ctrl_pkg.sv
// Shared control-unit definitions: FSM state encoding, instruction fields,
// datapath mux selects and ALU operation codes.
package cpu_ctrl_pkg;

    typedef enum logic [4:0] {
        ST_RESET     = 5'd0,
        ST_FETCH0    = 5'd1,
        ST_FETCH1    = 5'd2,
        ST_FETCH2    = 5'd3,
        ST_DECODE    = 5'd4,
        ST_R_EXEC    = 5'd5,
        ST_R_WB      = 5'd6,
        ST_JR        = 5'd7,
        ST_ADDI_EXEC = 5'd8,
        ST_ADDI_WB   = 5'd9,
        ST_MEM_ADDR  = 5'd10,
        ST_SW        = 5'd11,
        ST_LW0       = 5'd12,
        ST_LW1       = 5'd13,
        ST_LW2       = 5'd14,
        ST_LW_WB     = 5'd15,
        ST_BRANCH    = 5'd16,
        ST_J         = 5'd17,
        ST_JAL       = 5'd18,
        ST_EXC0      = 5'd19,
        ST_EXC1      = 5'd20,
        ST_EXC2      = 5'd21,
        ST_EXC3      = 5'd22,
        ST_EXC4      = 5'd23
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_JR  = 6'h08;
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;

    localparam logic [1:0] IORD_PC     = 2'd0;
    localparam logic [1:0] IORD_ERR    = 2'd1;
    localparam logic [1:0] IORD_ALUOUT = 2'd2;

    localparam logic [1:0] ERR_OPC = 2'd0;
    localparam logic [1:0] ERR_OVF = 2'd1;

    localparam logic [2:0] REGDST_RT = 3'd0;
    localparam logic [2:0] REGDST_RD = 3'd1;
    localparam logic [2:0] REGDST_RA = 3'd2;

    localparam logic [3:0] MEMTOREG_ALUOUT = 4'd1;
    localparam logic [3:0] MEMTOREG_PC     = 4'd8;
    localparam logic [3:0] MEMTOREG_LOAD   = 4'd9;

    localparam logic       SRCA_PC = 1'b0;
    localparam logic       SRCA_A  = 1'b1;

    localparam logic [1:0] SRCB_B        = 2'd0;
    localparam logic [1:0] SRCB_FOUR     = 2'd1;
    localparam logic [1:0] SRCB_SEXT     = 2'd2;
    localparam logic [1:0] SRCB_SEXT_SH2 = 2'd3;

    localparam logic [2:0] PCSRC_ALU    = 3'd0;
    localparam logic [2:0] PCSRC_ALUOUT = 3'd2;
    localparam logic [2:0] PCSRC_A      = 3'd3;
    localparam logic [2:0] PCSRC_JUMP   = 3'd4;
    localparam logic [2:0] PCSRC_LOAD   = 3'd5;

    localparam logic [2:0] ALU_ADD = 3'b001;
    localparam logic [2:0] ALU_SUB = 3'b010;
    localparam logic [2:0] ALU_AND = 3'b011;

    localparam logic [1:0] SIZE_WORD   = 2'd0;
    localparam logic [1:0] SIZE_BYTE   = 2'd2;
    localparam logic [1:0] MUXSHF_NONE = 2'd0;

    function automatic logic is_supported(input logic [5:0] op, input logic [5:0] fn);
        logic ok;
        case (op)
            OP_RTYPE: ok = (fn == FN_ADD) || (fn == FN_SUB) || (fn == FN_AND) || (fn == FN_JR);
            OP_J, OP_JAL, OP_BEQ, OP_BNE, OP_ADDI, OP_LW, OP_SW: ok = 1'b1;
            default:  ok = 1'b0;
        endcase
        return ok;
    endfunction

    function automatic logic [2:0] alu_op_for_funct(input logic [5:0] fn);
        logic [2:0] op;
        case (fn)
            FN_SUB:  op = ALU_SUB;
            FN_AND:  op = ALU_AND;
            default: op = ALU_ADD;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/ctrl_unit.sv
// Multicycle MIPS-subset control unit: Moore FSM whose strobes are decoded
// from the registered state (plus IR fields and, for branches, ULA_EQ).
module ctrl_unit
    import cpu_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] OPCODE,
    input  logic [5:0] FUNCT,
    input  logic       ULA_OVERFLOW,
    input  logic       ULA_ZERO,
    input  logic       ULA_EQ,
    output logic       PC_w,
    output logic       crtl_memwrite,
    output logic       crtl_irwrite,
    output logic       crtl_regwrite,
    output logic       crtl_ulasrca,
    output logic       crtl_memDataRegWrite,
    output logic       crtl_rega,
    output logic       crtl_regb,
    output logic       crtl_regaluout,
    output logic       crtl_regepc,
    output logic [1:0] crtl_error,
    output logic [1:0] crtl_iord,
    output logic [2:0] crtl_regdst,
    output logic [3:0] crtl_memtoreg,
    output logic [1:0] crtl_ulasrcb,
    output logic [2:0] crtl_pcsource,
    output logic [1:0] crtl_ls,
    output logic [1:0] crtl_ss,
    output logic [1:0] crtl_muxshf,
    output logic [2:0] ULA_CRTL_out
);

    state_t state_q;
    state_t state_d;
    logic   unused_zero_s;

    assign unused_zero_s = ULA_ZERO;

    // State register with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_RESET;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RESET:  state_d = ST_FETCH0;
            ST_FETCH0: state_d = ST_FETCH1;
            ST_FETCH1: state_d = ST_FETCH2;
            ST_FETCH2: state_d = ST_DECODE;
            ST_DECODE: begin
                if (!is_supported(OPCODE, FUNCT)) begin
                    state_d = ST_EXC0;
                end else begin
                    case (OPCODE)
                        OP_RTYPE:     state_d = (FUNCT == FN_JR) ? ST_JR : ST_R_EXEC;
                        OP_ADDI:      state_d = ST_ADDI_EXEC;
                        OP_LW, OP_SW: state_d = ST_MEM_ADDR;
                        OP_BEQ, OP_BNE: state_d = ST_BRANCH;
                        OP_J:         state_d = ST_J;
                        OP_JAL:       state_d = ST_JAL;
                        default:      state_d = ST_EXC0;
                    endcase
                end
            end
            // "and" cannot overflow, so only add/sub divert to the exception path
            ST_R_EXEC: begin
                if (ULA_OVERFLOW && ((FUNCT == FN_ADD) || (FUNCT == FN_SUB))) begin
                    state_d = ST_EXC0;
                end else begin
                    state_d = ST_R_WB;
                end
            end
            ST_ADDI_EXEC: state_d = ULA_OVERFLOW ? ST_EXC0 : ST_ADDI_WB;
            ST_MEM_ADDR:  state_d = (OPCODE == OP_SW) ? ST_SW : ST_LW0;
            ST_LW0:       state_d = ST_LW1;
            ST_LW1:       state_d = ST_LW2;
            ST_LW2:       state_d = ST_LW_WB;
            ST_EXC0:      state_d = ST_EXC1;
            ST_EXC1:      state_d = ST_EXC2;
            ST_EXC2:      state_d = ST_EXC3;
            ST_EXC3:      state_d = ST_EXC4;
            ST_R_WB, ST_JR, ST_ADDI_WB, ST_SW, ST_LW_WB,
            ST_BRANCH, ST_J, ST_JAL, ST_EXC4: state_d = ST_FETCH0;
            default:      state_d = ST_RESET;
        endcase
    end

    // Output decode
    always_comb begin
        PC_w                 = 1'b0;
        crtl_memwrite        = 1'b0;
        crtl_irwrite         = 1'b0;
        crtl_regwrite        = 1'b0;
        crtl_ulasrca         = SRCA_PC;
        crtl_memDataRegWrite = 1'b0;
        crtl_rega            = 1'b0;
        crtl_regb            = 1'b0;
        crtl_regaluout       = 1'b0;
        crtl_regepc          = 1'b0;
        crtl_error           = 2'd0;
        crtl_iord            = IORD_PC;
        crtl_regdst          = 3'd0;
        crtl_memtoreg        = 4'd0;
        crtl_ulasrcb         = 2'd0;
        crtl_pcsource        = 3'd0;
        crtl_ls              = 2'd0;
        crtl_ss              = 2'd0;
        crtl_muxshf          = MUXSHF_NONE;
        ULA_CRTL_out         = 3'd0;
        case (state_q)
            ST_FETCH0, ST_FETCH1: begin
                crtl_iord    = IORD_PC;
                crtl_ulasrca = SRCA_PC;
                crtl_ulasrcb = SRCB_FOUR;
                ULA_CRTL_out = ALU_ADD;
            end
            // ALU keeps producing PC+4 so the PC write picks it up directly
            ST_FETCH2: begin
                crtl_ulasrca  = SRCA_PC;
                crtl_ulasrcb  = SRCB_FOUR;
                ULA_CRTL_out  = ALU_ADD;
                crtl_irwrite  = 1'b1;
                PC_w          = 1'b1;
                crtl_pcsource = PCSRC_ALU;
            end
            ST_DECODE: begin
                crtl_rega      = 1'b1;
                crtl_regb      = 1'b1;
                crtl_ulasrca   = SRCA_PC;
                crtl_ulasrcb   = SRCB_SEXT_SH2;
                ULA_CRTL_out   = ALU_ADD;
                crtl_regaluout = 1'b1;
            end
            ST_R_EXEC: begin
                crtl_ulasrca   = SRCA_A;
                crtl_ulasrcb   = SRCB_B;
                ULA_CRTL_out   = alu_op_for_funct(FUNCT);
                crtl_regaluout = 1'b1;
            end
            ST_R_WB: begin
                crtl_regdst   = REGDST_RD;
                crtl_memtoreg = MEMTOREG_ALUOUT;
                crtl_regwrite = 1'b1;
            end
            ST_JR: begin
                crtl_pcsource = PCSRC_A;
                PC_w          = 1'b1;
            end
            ST_ADDI_EXEC, ST_MEM_ADDR: begin
                crtl_ulasrca   = SRCA_A;
                crtl_ulasrcb   = SRCB_SEXT;
                ULA_CRTL_out   = ALU_ADD;
                crtl_regaluout = 1'b1;
            end
            ST_ADDI_WB: begin
                crtl_regdst   = REGDST_RT;
                crtl_memtoreg = MEMTOREG_ALUOUT;
                crtl_regwrite = 1'b1;
            end
            ST_SW: begin
                crtl_iord     = IORD_ALUOUT;
                crtl_memwrite = 1'b1;
                crtl_ss       = SIZE_WORD;
            end
            ST_LW0, ST_LW1: crtl_iord = IORD_ALUOUT;
            ST_LW2:         crtl_memDataRegWrite = 1'b1;
            ST_LW_WB: begin
                crtl_regdst   = REGDST_RT;
                crtl_memtoreg = MEMTOREG_LOAD;
                crtl_ls       = SIZE_WORD;
                crtl_regwrite = 1'b1;
            end
            ST_BRANCH: begin
                crtl_ulasrca  = SRCA_A;
                crtl_ulasrcb  = SRCB_B;
                ULA_CRTL_out  = ALU_SUB;
                crtl_pcsource = PCSRC_ALUOUT;
                PC_w          = (OPCODE == OP_BEQ) ? ULA_EQ : ~ULA_EQ;
            end
            ST_J: begin
                crtl_pcsource = PCSRC_JUMP;
                PC_w          = 1'b1;
            end
            ST_JAL: begin
                crtl_regdst   = REGDST_RA;
                crtl_memtoreg = MEMTOREG_PC;
                crtl_regwrite = 1'b1;
                crtl_pcsource = PCSRC_JUMP;
                PC_w          = 1'b1;
            end
            ST_EXC0: begin
                crtl_ulasrca = SRCA_PC;
                crtl_ulasrcb = SRCB_FOUR;
                ULA_CRTL_out = ALU_SUB;
                crtl_regepc  = 1'b1;
            end
            // IR is stable through the handler, so the cause follows from it
            ST_EXC1, ST_EXC2: begin
                crtl_iord  = IORD_ERR;
                crtl_error = is_supported(OPCODE, FUNCT) ? ERR_OVF : ERR_OPC;
            end
            ST_EXC3: crtl_memDataRegWrite = 1'b1;
            ST_EXC4: begin
                crtl_ls       = SIZE_BYTE;
                crtl_pcsource = PCSRC_LOAD;
                PC_w          = 1'b1;
            end
            default: begin
                PC_w = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_ctrl_unit.sv
// Directed bench for ctrl_unit: a per-instruction cycle-sequence model feeds
// an expectation queue that is compared against the DUT every cycle.
module tb_ctrl_unit;

    typedef struct packed {
        logic       pc_w;
        logic       memwrite;
        logic       irwrite;
        logic       regwrite;
        logic       ulasrca;
        logic       mdrw;
        logic       rega;
        logic       regb;
        logic       regaluout;
        logic       regepc;
        logic [1:0] error;
        logic [1:0] iord;
        logic [2:0] regdst;
        logic [3:0] memtoreg;
        logic [1:0] ulasrcb;
        logic [2:0] pcsource;
        logic [1:0] ls;
        logic [1:0] ss;
        logic [1:0] muxshf;
        logic [2:0] alu;
    } outs_t;

    logic       clk;
    logic       rst;
    logic [5:0] OPCODE;
    logic [5:0] FUNCT;
    logic       ULA_OVERFLOW, ULA_ZERO, ULA_EQ;
    logic       PC_w, crtl_memwrite, crtl_irwrite, crtl_regwrite, crtl_ulasrca;
    logic       crtl_memDataRegWrite, crtl_rega, crtl_regb, crtl_regaluout, crtl_regepc;
    logic [1:0] crtl_error, crtl_iord, crtl_ulasrcb, crtl_ls, crtl_ss, crtl_muxshf;
    logic [2:0] crtl_regdst, crtl_pcsource, ULA_CRTL_out;
    logic [3:0] crtl_memtoreg;
    outs_t      dut_o;

    int    checks = 0;
    int    errors = 0;
    int    step   = 0;
    outs_t exp_q[$];
    outs_t plan_q[$];

    ctrl_unit dut (
        .clk(clk), .rst(rst), .OPCODE(OPCODE), .FUNCT(FUNCT),
        .ULA_OVERFLOW(ULA_OVERFLOW), .ULA_ZERO(ULA_ZERO), .ULA_EQ(ULA_EQ),
        .PC_w(PC_w), .crtl_memwrite(crtl_memwrite), .crtl_irwrite(crtl_irwrite),
        .crtl_regwrite(crtl_regwrite), .crtl_ulasrca(crtl_ulasrca),
        .crtl_memDataRegWrite(crtl_memDataRegWrite), .crtl_rega(crtl_rega),
        .crtl_regb(crtl_regb), .crtl_regaluout(crtl_regaluout), .crtl_regepc(crtl_regepc),
        .crtl_error(crtl_error), .crtl_iord(crtl_iord), .crtl_regdst(crtl_regdst),
        .crtl_memtoreg(crtl_memtoreg), .crtl_ulasrcb(crtl_ulasrcb),
        .crtl_pcsource(crtl_pcsource), .crtl_ls(crtl_ls), .crtl_ss(crtl_ss),
        .crtl_muxshf(crtl_muxshf), .ULA_CRTL_out(ULA_CRTL_out)
    );

    assign dut_o = {PC_w, crtl_memwrite, crtl_irwrite, crtl_regwrite, crtl_ulasrca,
                    crtl_memDataRegWrite, crtl_rega, crtl_regb, crtl_regaluout, crtl_regepc,
                    crtl_error, crtl_iord, crtl_regdst, crtl_memtoreg, crtl_ulasrcb,
                    crtl_pcsource, crtl_ls, crtl_ss, crtl_muxshf, ULA_CRTL_out};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare DUT outputs against the expected sequence, once per cycle
    always @(negedge clk) begin
        outs_t e;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            step++;
            checks++;
            if (dut_o !== e) begin
                errors++;
                $display("FAIL cycle_outputs step=%0d got=%h want=%h", step, dut_o, e);
            end
            checks++;
            if (crtl_memwrite === 1'b1 && crtl_regwrite === 1'b1) begin
                errors++;
                $display("FAIL mem_reg_exclusive step=%0d got=both want=not_both", step);
            end
        end
    end

    task automatic push_exc(input logic [1:0] cause);
        outs_t o;
        o = '0; o.ulasrcb = 2'd1; o.alu = 3'b010; o.regepc = 1'b1;
        plan_q.push_back(o);
        o = '0; o.iord = 2'd1; o.error = cause;
        plan_q.push_back(o);
        plan_q.push_back(o);
        o = '0; o.mdrw = 1'b1;
        plan_q.push_back(o);
        o = '0; o.ls = 2'd2; o.pcsource = 3'd5; o.pc_w = 1'b1;
        plan_q.push_back(o);
    endtask

    // Whole-instruction model: the cycle-by-cycle outputs from FETCH0 onward
    task automatic plan(input logic [5:0] op, input logic [5:0] fn, input logic ovf, input logic eq);
        outs_t o;
        logic  is_r;
        plan_q.delete();
        is_r = (op == 6'h00);
        o = '0; o.ulasrcb = 2'd1; o.alu = 3'b001;
        plan_q.push_back(o);
        plan_q.push_back(o);
        o.irwrite = 1'b1; o.pc_w = 1'b1;
        plan_q.push_back(o);
        o = '0; o.rega = 1'b1; o.regb = 1'b1; o.ulasrcb = 2'd3; o.alu = 3'b001; o.regaluout = 1'b1;
        plan_q.push_back(o);
        if (is_r && (fn == 6'h20 || fn == 6'h22 || fn == 6'h24)) begin
            o = '0; o.ulasrca = 1'b1; o.regaluout = 1'b1;
            o.alu = (fn == 6'h20) ? 3'b001 : ((fn == 6'h22) ? 3'b010 : 3'b011);
            plan_q.push_back(o);
            if (ovf && fn != 6'h24) begin
                push_exc(2'd1);
            end else begin
                o = '0; o.regdst = 3'd1; o.memtoreg = 4'd1; o.regwrite = 1'b1;
                plan_q.push_back(o);
            end
        end else if (is_r && fn == 6'h08) begin
            o = '0; o.pcsource = 3'd3; o.pc_w = 1'b1;
            plan_q.push_back(o);
        end else if (op == 6'h08) begin
            o = '0; o.ulasrca = 1'b1; o.ulasrcb = 2'd2; o.alu = 3'b001; o.regaluout = 1'b1;
            plan_q.push_back(o);
            if (ovf) begin
                push_exc(2'd1);
            end else begin
                o = '0; o.memtoreg = 4'd1; o.regwrite = 1'b1;
                plan_q.push_back(o);
            end
        end else if (op == 6'h23 || op == 6'h2B) begin
            o = '0; o.ulasrca = 1'b1; o.ulasrcb = 2'd2; o.alu = 3'b001; o.regaluout = 1'b1;
            plan_q.push_back(o);
            if (op == 6'h2B) begin
                o = '0; o.iord = 2'd2; o.memwrite = 1'b1;
                plan_q.push_back(o);
            end else begin
                o = '0; o.iord = 2'd2;
                plan_q.push_back(o);
                plan_q.push_back(o);
                o = '0; o.mdrw = 1'b1;
                plan_q.push_back(o);
                o = '0; o.memtoreg = 4'd9; o.regwrite = 1'b1;
                plan_q.push_back(o);
            end
        end else if (op == 6'h04 || op == 6'h05) begin
            o = '0; o.ulasrca = 1'b1; o.alu = 3'b010; o.pcsource = 3'd2;
            o.pc_w = (op == 6'h04) ? eq : !eq;
            plan_q.push_back(o);
        end else if (op == 6'h02) begin
            o = '0; o.pcsource = 3'd4; o.pc_w = 1'b1;
            plan_q.push_back(o);
        end else if (op == 6'h03) begin
            o = '0; o.regdst = 3'd2; o.memtoreg = 4'd8; o.regwrite = 1'b1;
            o.pcsource = 3'd4; o.pc_w = 1'b1;
            plan_q.push_back(o);
        end else begin
            push_exc(2'd0);
        end
    endtask

    // Drive one instruction; cut > 0 stops after that many cycles
    task automatic run(input logic [5:0] op, input logic [5:0] fn, input logic ovf,
                       input logic eq, input int cut);
        int n;
        OPCODE = op; FUNCT = fn; ULA_OVERFLOW = ovf; ULA_EQ = eq;
        ULA_ZERO = eq;
        plan(op, fn, ovf, eq);
        n = (cut > 0) ? cut : plan_q.size();
        for (int i = 0; i < n; i++) exp_q.push_back(plan_q[i]);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        exp_q.push_back('0);
        @(negedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic spot(input string name, input int act, input int want);
        checks++;
        if (act != want) begin
            errors++;
            $display("FAIL %s got=%0d want=%0d", name, act, want);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; OPCODE = 6'h00; FUNCT = 6'h00;
        ULA_OVERFLOW = 1'b0; ULA_ZERO = 1'b0; ULA_EQ = 1'b0;
        @(negedge clk);
        #1;
        do_reset();

        run(6'h00, 6'h20, 1'b0, 1'b0, 0);
        spot("radd_latency", plan_q.size(), 6);
        spot("radd_regwrite", int'(crtl_regwrite), 1);
        spot("radd_regdst", int'(crtl_regdst), 1);
        spot("radd_memtoreg", int'(crtl_memtoreg), 1);
        run(6'h00, 6'h22, 1'b0, 1'b0, 0);
        run(6'h00, 6'h24, 1'b1, 1'b0, 0);
        spot("rand_ovf_ignored", int'(crtl_regwrite), 1);
        run(6'h00, 6'h20, 1'b1, 1'b0, 0);
        spot("radd_ovf_pcsource", int'(crtl_pcsource), 5);
        run(6'h00, 6'h08, 1'b0, 1'b0, 0);
        spot("jr_latency", plan_q.size(), 5);
        spot("jr_pcsource", int'(crtl_pcsource), 3);
        run(6'h08, 6'h11, 1'b0, 1'b0, 0);
        run(6'h08, 6'h11, 1'b1, 1'b0, 0);
        spot("addi_ovf_pcw", int'(PC_w), 1);
        spot("addi_ovf_pcsource", int'(crtl_pcsource), 5);
        spot("addi_ovf_regwrite", int'(crtl_regwrite), 0);
        run(6'h23, 6'h05, 1'b0, 1'b0, 0);
        spot("lw_latency", plan_q.size(), 9);
        spot("lw_memtoreg", int'(crtl_memtoreg), 9);
        spot("lw_regwrite", int'(crtl_regwrite), 1);
        run(6'h2B, 6'h05, 1'b0, 1'b0, 0);
        spot("sw_latency", plan_q.size(), 6);
        run(6'h04, 6'h00, 1'b0, 1'b1, 0);
        spot("beq_taken_pcw", int'(PC_w), 1);
        spot("beq_taken_pcsource", int'(crtl_pcsource), 2);
        run(6'h04, 6'h00, 1'b0, 1'b0, 0);
        spot("beq_not_taken_pcw", int'(PC_w), 0);
        run(6'h05, 6'h00, 1'b0, 1'b1, 0);
        spot("bne_eq_pcw", int'(PC_w), 0);
        run(6'h05, 6'h00, 1'b0, 1'b0, 0);
        spot("bne_ne_pcw", int'(PC_w), 1);
        run(6'h02, 6'h00, 1'b0, 1'b0, 0);
        run(6'h03, 6'h00, 1'b0, 1'b0, 0);
        spot("jal_latency", plan_q.size(), 5);
        spot("jal_regdst", int'(crtl_regdst), 2);
        spot("jal_memtoreg", int'(crtl_memtoreg), 8);
        run(6'h3F, 6'h00, 1'b0, 1'b0, 0);
        run(6'h00, 6'h3F, 1'b0, 1'b0, 0);

        run(6'h23, 6'h00, 1'b0, 1'b0, 7);
        spot("lw1_iord", int'(crtl_iord), 2);
        do_reset();
        run(6'h08, 6'h00, 1'b1, 1'b0, 7);
        spot("exc1_error", int'(crtl_error), 1);
        do_reset();
        run(6'h00, 6'h20, 1'b0, 1'b0, 0);
        spot("queue_drained", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
